// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind an SPI slave: rising-edge command accept,
// 3-state read pipeline with a one-deep pending read. Optional burst mode: RAM_AUTO_INC_EN.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_RESP} state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  state_t               state, state_nxt;
  logic                 rx_valid_d;
  logic                 pending, pending_nxt;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wa_ok, ra_ok;
  logic [7:0]           mem [MEM_DEPTH];
  logic [1:0]           opcode;
  logic                 cmd_acc_p0;
  logic                 rd_req_p0;
  logic                 wr_en_p0;
  logic                 err_nxt;

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return (int'(a) < MEM_DEPTH);
  endfunction

`ifdef RAM_AUTO_INC_EN
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    if (int'(a) >= MEM_DEPTH - 1) return '0;
    return a + 1'b1;
  endfunction
`endif

  assign opcode = din[9:8];

  // Stage p0: edge-detect rx_valid, decode, and plan the read pipeline
  always_comb begin
    cmd_acc_p0  = rx_valid & ~rx_valid_d;
    rd_req_p0   = 1'b0;
    wr_en_p0    = 1'b0;
    err_nxt     = 1'b0;
    state_nxt   = state;
    pending_nxt = pending;

    if (cmd_acc_p0) begin
      case (opcode)
        OP_WR_DATA: begin
          wr_en_p0 = in_range(wr_addr);
          if (!wa_ok || !in_range(wr_addr)) err_nxt = 1'b1;
        end
        OP_RD_DATA: begin
          rd_req_p0 = 1'b1;
          if (!ra_ok || !in_range(rd_addr)) err_nxt = 1'b1;
        end
        default: ;
      endcase
    end

    case (state)
      IDLE: begin
        if (pending || rd_req_p0) begin
          state_nxt   = RD_ISSUE;
          pending_nxt = pending && rd_req_p0;
        end
      end
      RD_ISSUE: state_nxt = RD_RESP;
      default:  state_nxt = IDLE;
    endcase

    // Reads arriving mid-pipeline park in the single pending slot; overflow is dropped
    if (state != IDLE && rd_req_p0) begin
      if (pending) err_nxt = 1'b1;
      else         pending_nxt = 1'b1;
    end
  end

  // Stage p1: control state, address registers and read response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      rx_valid_d <= 1'b1;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wa_ok      <= 1'b0;
      ra_ok      <= 1'b0;
      dout       <= 8'h00;
      tx_valid   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      rx_valid_d <= rx_valid;
      cmd_err    <= err_nxt;
      tx_valid   <= (state == RD_ISSUE);
      if (state == RD_ISSUE) dout <= in_range(rd_addr) ? mem[rd_addr] : 8'h00;
`ifdef RAM_AUTO_INC_EN
      if (state == RD_ISSUE) rd_addr <= next_addr(rd_addr);
      if (wr_en_p0)          wr_addr <= next_addr(wr_addr);
`endif
      if (cmd_acc_p0 && opcode == OP_WR_ADDR) begin
        wr_addr <= din[ADDR_SIZE-1:0];
        wa_ok   <= 1'b1;
      end
      if (cmd_acc_p0 && opcode == OP_RD_ADDR) begin
        rd_addr <= din[ADDR_SIZE-1:0];
        ra_ok   <= 1'b1;
      end
    end
  end

  // Array contents survive reset; writes are only blocked while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_p0) mem[wr_addr] <= din[7:0];
  end

endmodule
